// File: rtl/opsum_drain_controller.sv
// Output-psum drain: pops LANES-word beats from the GON FIFO, serialises them through
// a small word buffer and writes each word to the GLB at a 4-D (n,m,e,F) address.
module opsum_drain_controller #(
  parameter int F_WIDTH    = 6,
  parameter int m_WIDTH    = 10,
  parameter int n_WIDTH    = 3,
  parameter int e_WIDTH    = 8,
  parameter int LANES      = 4,
  parameter int WORD_WIDTH = 16,
  parameter int BUF_DEPTH  = 16,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        row_major,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [F_WIDTH-1:0]          F,
  input  logic [m_WIDTH-1:0]          m,
  input  logic [n_WIDTH-1:0]          n,
  input  logic [e_WIDTH-1:0]          e,
  output logic                        busy,
  output logic                        done,
  input  logic                        gon_fifo_empty,
  output logic                        re_from_gon_fifo,
  input  logic [LANES*WORD_WIDTH-1:0] din,
  input  logic                        glb_ready,
  output logic                        we_to_glb,
  output logic [ADDR_WIDTH-1:0]       addr,
  output logic [WORD_WIDTH-1:0]       dout,
  output logic [1:0]                  fsm_state
);

  // Handshakes: a GON pop happens on every cycle re_from_gon_fifo=1 (din valid in that
  // same cycle); a GLB write happens on every cycle we_to_glb=1, which already
  // includes glb_ready, so addr/dout are consumed exactly when we_to_glb is high.

  localparam int TOTAL_W = n_WIDTH + m_WIDTH + e_WIDTH + F_WIDTH;
  localparam int FE_W    = F_WIDTH + e_WIDTH;
  localparam int PTR_W   = $clog2(BUF_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TAKE_W  = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;

  logic [F_WIDTH-1:0]          f_q, i1;
  logic [e_WIDTH-1:0]          e_q, i2;
  logic [m_WIDTH-1:0]          m_q, i3;
  logic [n_WIDTH-1:0]          n_q, i4;
  logic                        row_major_q;
  logic [ADDR_WIDTH-1:0]       wrap_step;
  logic [TOTAL_W-1:0]          total, popped;

  logic [WORD_WIDTH-1:0]       mem [BUF_DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            count;
  logic                        pend_valid;
  logic [TAKE_W-1:0]           pend_cnt;
  logic [LANES*WORD_WIDTH-1:0] pend_data;

  logic [TOTAL_W-1:0]          remaining;
  logic [TAKE_W-1:0]           take;
  logic [CNT_W-1:0]            pend_words;
  logic [CNT_W-1:0]            free;
  logic                        last_i1, last_i2, last_i3, last_i4, last_tuple;
  logic [ADDR_WIDTH-1:0]       addr_step;
  logic [FE_W-1:0]             fe_prod;
  logic [ADDR_WIDTH-1:0]       cfg_wrap;
  logic [TOTAL_W-1:0]          cfg_total;
  logic                        cfg_zero;

  always_comb begin
    remaining  = total - popped;
    take       = (remaining >= TOTAL_W'(LANES)) ? TAKE_W'(LANES) : TAKE_W'(remaining);
    pend_words = pend_valid ? CNT_W'(pend_cnt) : '0;
    free       = CNT_W'(BUF_DEPTH) - count - pend_words;

    re_from_gon_fifo = (state == RUN) && !gon_fifo_empty &&
                       (free >= CNT_W'(LANES)) && (popped < total);
    we_to_glb        = (state == RUN) && (count != '0) && glb_ready;
    dout             = we_to_glb ? mem[rd_ptr] : '0;

    last_i1    = (i1 == f_q - F_WIDTH'(1));
    last_i2    = (i2 == e_q - e_WIDTH'(1));
    last_i3    = (i3 == m_q - m_WIDTH'(1));
    last_i4    = (i4 == n_q - n_WIDTH'(1));
    last_tuple = last_i1 && last_i2 && last_i3 && last_i4;

    // Col-major: +e along idx1, jump back (F-1)*e and +1 on idx1 wrap, and +1 when
    // idx2 also wraps because the next (m,n) block starts right after this one.
    if (row_major_q)   addr_step = ADDR_WIDTH'(1);
    else if (!last_i1) addr_step = ADDR_WIDTH'(e_q);
    else if (last_i2)  addr_step = ADDR_WIDTH'(1);
    else               addr_step = wrap_step;

    fe_prod   = FE_W'(F - F_WIDTH'(1)) * FE_W'(e);
    cfg_wrap  = ADDR_WIDTH'(1) - ADDR_WIDTH'(fe_prod);
    cfg_total = TOTAL_W'(n) * TOTAL_W'(m) * TOTAL_W'(e) * TOTAL_W'(F);
    cfg_zero  = (F == '0) || (m == '0) || (n == '0) || (e == '0);
  end

  assign busy      = (state == RUN);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      addr        <= '0;
      f_q         <= '0;
      e_q         <= '0;
      m_q         <= '0;
      n_q         <= '0;
      i1          <= '0;
      i2          <= '0;
      i3          <= '0;
      i4          <= '0;
      row_major_q <= 1'b0;
      wrap_step   <= '0;
      total       <= '0;
      popped      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pend_valid  <= 1'b0;
      pend_cnt    <= '0;
      pend_data   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f_q         <= F;
            e_q         <= e;
            m_q         <= m;
            n_q         <= n;
            row_major_q <= row_major;
            wrap_step   <= cfg_wrap;
            total       <= cfg_total;
            addr        <= base_addr;
            i1          <= '0;
            i2          <= '0;
            i3          <= '0;
            i4          <= '0;
            popped      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pend_valid  <= 1'b0;
            state       <= cfg_zero ? FIN : RUN;
          end
        end
        RUN: begin
          // Beat popped this cycle lands in the buffer next cycle, trimmed to TOTAL.
          if (re_from_gon_fifo) begin
            pend_valid <= 1'b1;
            pend_data  <= din;
            pend_cnt   <= take;
            popped     <= popped + TOTAL_W'(take);
          end else begin
            pend_valid <= 1'b0;
          end
          if (pend_valid) wr_ptr <= wr_ptr + PTR_W'(pend_cnt);
          count <= count + pend_words - CNT_W'(we_to_glb);
          if (we_to_glb) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            addr   <= addr + addr_step;
            if (last_i1) begin
              i1 <= '0;
              if (last_i2) begin
                i2 <= '0;
                if (last_i3) begin
                  i3 <= '0;
                  i4 <= last_i4 ? '0 : i4 + n_WIDTH'(1);
                end else begin
                  i3 <= i3 + m_WIDTH'(1);
                end
              end else begin
                i2 <= i2 + e_WIDTH'(1);
              end
            end else begin
              i1 <= i1 + F_WIDTH'(1);
            end
            if (last_tuple) state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RUN && pend_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (TAKE_W'(i) < pend_cnt)
          mem[wr_ptr + PTR_W'(i)] <= pend_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule
